// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared datapath types for the pipelined CPU. This file holds only the
// machine word type and its width, which the memory arbiter uses for every
// address and data bus.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg
// Types for the memory arbiter:
//   arb_state_t : arbiter FSM states (idle, instruction access, data access)
//   ARB_REQ_I / ARB_REQ_D : requester identifiers. The round-robin build
//                           stores one of these to remember who was served last.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IACC = 2'd1,
    ARB_DACC = 2'd2
  } arb_state_t;

  localparam logic ARB_REQ_I = 1'b0;
  localparam logic ARB_REQ_D = 1'b1;

endpackage : diaosi_types_pkg

// File: rtl/arb_watchdog.sv
// arb_watchdog
// Counts the access cycles that pass without a RAM ready. It flags expiry in
// the cycle in which the count would reach TIMEOUT, so an access that has not
// finished after TIMEOUT cycles is aborted at the end of that cycle.
// Ports:
//   i_clk      : clock, rising edge
//   i_nrst     : synchronous active-low reset
//   i_clear    : restart the count. Asserted when a new access is granted.
//   i_count_en : an access cycle is passing without ram_rdy
//   o_expired  : this cycle is the TIMEOUT-th cycle without completion
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  // The counter restarts on every grant and advances only while the granted
  // access is stalled. It never passes TIMEOUT, because expiry drops the
  // arbiter back to idle.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry looks ahead one increment. The abort then lands on the same edge
  // at which the count reaches TIMEOUT.
  assign o_expired = i_count_en && (r_count == CNT_W'(TIMEOUT - 1));

endmodule : arb_watchdog

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the single unified RAM port between instruction fetch and data memory.
// A three-state FSM grants one requester at a time. Every access runs under
// a watchdog, and a timeout sets the sticky arb_err flag.
// Configuration macro:
//   MEM_ARB_RR_EN : when defined, ties are broken round-robin. When undefined,
//                   data always wins over instruction.
// Ports:
//   CLK, nRST                 : clock (rising edge), synchronous active-low reset
//   iREN, iaddr               : instruction read request and address
//   iload, iwait              : instruction read data, 1 = instruction not complete
//   dREN, dWEN, daddr, dstore : data read/write request, address, write data
//   dload, dwait              : data read value, 1 = data not complete
//   ramREN, ramWEN            : RAM read and write strobes
//   ramaddr, ramstore         : RAM address and write data
//   ramload, ram_rdy          : RAM read data, RAM access complete
//   arb_err                   : sticky watchdog timeout flag
module memory_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output word_t iload,
  output logic  iwait,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output word_t dload,
  output logic  dwait,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_rdy,
  output logic  arb_err
);

  arb_state_t r_state;
  logic       r_arbErr;
  logic       w_dReq;
  logic       w_grantD;
  logic       w_wdClear;
  logic       w_wdCountEn;
  logic       w_expired;

  assign w_dReq = dREN | dWEN;

`ifdef MEM_ARB_RR_EN
  logic r_lastGrant;

  // On a tie, the requester that was not served last gets the grant. If
  // instruction went last, data takes this one.
  assign w_grantD = w_dReq & (~iREN | (r_lastGrant == ARB_REQ_I));
`else
  assign w_grantD = w_dReq;
`endif

  // The watchdog restarts on every grant out of idle. It counts only while
  // the granted requester still wants the access and the RAM has not
  // answered, so a dropped request never raises an error.
  assign w_wdClear   = (r_state == ARB_IDLE) & (w_dReq | iREN);
  assign w_wdCountEn = ~ram_rdy & (((r_state == ARB_IACC) & iREN) |
                                   ((r_state == ARB_DACC) & w_dReq));

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk      (CLK),
    .i_nrst     (nRST),
    .i_clear    (w_wdClear),
    .i_count_en (w_wdCountEn),
    .o_expired  (w_expired)
  );

  // Arbiter FSM. Each access returns to idle, so back-to-back grants are
  // always one idle cycle apart. Completion is checked before the drop and
  // timeout conditions, so a ready in the timeout cycle still completes the
  // access normally.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= ARB_IDLE;
      r_arbErr    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_lastGrant <= ARB_REQ_I;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grantD) begin
            r_state <= ARB_DACC;
          end else if (iREN) begin
            r_state <= ARB_IACC;
          end
        end
        ARB_IACC: begin
          if (ram_rdy) begin
            r_state     <= ARB_IDLE;
`ifdef MEM_ARB_RR_EN
            r_lastGrant <= ARB_REQ_I;
`endif
          end else if (!iREN) begin
            r_state <= ARB_IDLE;
          end else if (w_expired) begin
            r_state  <= ARB_IDLE;
            r_arbErr <= 1'b1;
          end
        end
        ARB_DACC: begin
          if (ram_rdy) begin
            r_state     <= ARB_IDLE;
`ifdef MEM_ARB_RR_EN
            r_lastGrant <= ARB_REQ_D;
`endif
          end else if (!w_dReq) begin
            r_state <= ARB_IDLE;
          end else if (w_expired) begin
            r_state  <= ARB_IDLE;
            r_arbErr <= 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // RAM port steering. It is decoded from the registered state plus the
  // requester's own enables, so strobes drop in the same cycle as a
  // withdrawn request. ram_rdy reaches only the wait outputs and never the
  // strobes.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      ARB_IACC: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~ram_rdy;
      end
      ARB_DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~ram_rdy;
      end
      default: begin
      end
    endcase
  end

  assign arb_err = r_arbErr;

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter with TIMEOUT=16. Each cycle's expected
// outputs are pushed to a scoreboard queue when the stimulus is applied. They
// are popped and compared on the falling edge, when the DUT outputs are settled.
// It follows MEM_ARB_RR_EN for the tie-break expectations.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 16;

  logic  CLK;
  logic  nRST;
  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  iwait;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dwait;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_rdy;
  logic  arb_err;

  typedef struct {
    string        tag;
    logic [132:0] vec;
  } exp_t;

  exp_t sbQ[$];
  int   testCount = 0;
  int   failCount = 0;

  memory_arbiter #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_rdy  (ram_rdy),
    .arb_err  (arb_err)
  );

  // Free-running clock, 10 time units per period
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Output bundle layout: {iwait, dwait, ramREN, ramWEN, arb_err,
  // ramaddr, ramstore, iload, dload}
  function automatic logic [132:0] mk(logic iw, logic dw, logic rR, logic rW,
                                      logic err, word_t addr, word_t store,
                                      word_t il, word_t dl);
    return {iw, dw, rR, rW, err, addr, store, il, dl};
  endfunction

  function automatic logic [132:0] idleE(logic err);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, err, '0, '0, '0, '0);
  endfunction

  function automatic logic [132:0] iaccE(logic ren, logic rdy, word_t addr,
                                         word_t load, logic err);
    return mk(~rdy, 1'b1, ren, 1'b0, err, addr, '0, load, '0);
  endfunction

  function automatic logic [132:0] daccE(logic ren, logic wen, logic rdy,
                                         word_t addr, word_t store,
                                         word_t load, logic err);
    return mk(1'b1, ~rdy, ren & ~wen, wen, err, addr, store, '0, load);
  endfunction

  // Records the expected outputs for the cycle whose inputs were just driven
  task automatic applyStimulus(input string tag, input logic [132:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    sbQ.push_back(e);
  endtask

  // Pops one expectation, compares it on the falling edge, then advances to
  // just after the next rising edge so the following inputs can be driven
  task automatic checkOutput();
    exp_t         e;
    logic [132:0] obs;
    @(negedge CLK);
    obs = {iwait, dwait, ramREN, ramWEN, arb_err, ramaddr, ramstore, iload, dload};
    testCount++;
    if (sbQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.vec) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h required %h", e.tag, obs, e.vec);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle(input string tag, input logic [132:0] vec);
    applyStimulus(tag, vec);
    checkOutput();
  endtask

  initial begin
    logic mLastD;
    logic grantD;

    nRST    = 1'b0;
    iREN    = 1'b0;
    iaddr   = '0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    daddr   = '0;
    dstore  = '0;
    ramload = '0;
    ram_rdy = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    cycle("reset_state", idleE(1'b0));

    // Single-cycle instruction fetch with ram_rdy in the first access cycle
    nRST    = 1'b1;
    iREN    = 1'b1;
    iaddr   = 32'h0000_0040;
    ram_rdy = 1'b1;
    ramload = 32'h8C01_0004;
    cycle("ifetch_req", idleE(1'b0));
    cycle("ifetch_acc", iaccE(1'b1, 1'b1, 32'h40, 32'h8C01_0004, 1'b0));
    iREN    = 1'b0;
    ram_rdy = 1'b0;
    cycle("ifetch_idle", idleE(1'b0));

    // Instruction and data write requested together: data goes first
    iREN    = 1'b1;
    iaddr   = 32'h0000_0044;
    dWEN    = 1'b1;
    daddr   = 32'h0000_0100;
    dstore  = 32'hDEAD_BEEF;
    ramload = 32'h1111_1111;
    cycle("tie_req", idleE(1'b0));
    cycle("tie_dacc_wait", daccE(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0));
    ram_rdy = 1'b1;
    cycle("tie_dacc_done", daccE(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0));
    dWEN    = 1'b0;
    ram_rdy = 1'b0;
    cycle("tie_gap", idleE(1'b0));
    ram_rdy = 1'b1;
    ramload = 32'h2222_2222;
    cycle("tie_iacc_done", iaccE(1'b1, 1'b1, 32'h44, 32'h2222_2222, 1'b0));
    iREN    = 1'b0;
    ram_rdy = 1'b0;
    cycle("tie_idle", idleE(1'b0));

    // Sustained requests on both sides: the grant order depends on the build.
    // The last completed access above was an instruction fetch.
    mLastD  = 1'b0;
    iREN    = 1'b1;
    iaddr   = 32'h0000_0048;
    dREN    = 1'b1;
    daddr   = 32'h0000_0200;
    dstore  = 32'h0;
    ram_rdy = 1'b1;
    ramload = 32'h3333_3333;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      grantD = ~mLastD;
`else
      grantD = 1'b1;
`endif
      cycle($sformatf("sustain_idle%0d", k), idleE(1'b0));
      if (grantD) begin
        cycle($sformatf("sustain_grant%0d", k),
              daccE(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h3333_3333, 1'b0));
      end else begin
        cycle($sformatf("sustain_grant%0d", k),
              iaccE(1'b1, 1'b1, 32'h48, 32'h3333_3333, 1'b0));
      end
      mLastD = grantD;
    end
    iREN    = 1'b0;
    dREN    = 1'b0;
    ram_rdy = 1'b0;
    cycle("sustain_end", idleE(1'b0));

    // Read and write both requested: the access is a write
    dREN    = 1'b1;
    dWEN    = 1'b1;
    daddr   = 32'h0000_0104;
    dstore  = 32'hCAFE_F00D;
    ramload = 32'h4444_4444;
    cycle("rw_req", idleE(1'b0));
    ram_rdy = 1'b1;
    cycle("rw_acc", daccE(1'b1, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 32'h4444_4444, 1'b0));
    dREN    = 1'b0;
    dWEN    = 1'b0;
    ram_rdy = 1'b0;
    cycle("rw_idle", idleE(1'b0));

    // ram_rdy arrives exactly in access cycle TIMEOUT: the access completes
    iREN    = 1'b1;
    iaddr   = 32'h0000_0050;
    ramload = 32'h5555_5555;
    cycle("edge_req", idleE(1'b0));
    for (int c = 1; c < TIMEOUT; c++) begin
      cycle($sformatf("edge_wait%0d", c), iaccE(1'b1, 1'b0, 32'h50, 32'h5555_5555, 1'b0));
    end
    ram_rdy = 1'b1;
    cycle("edge_done", iaccE(1'b1, 1'b1, 32'h50, 32'h5555_5555, 1'b0));
    iREN    = 1'b0;
    ram_rdy = 1'b0;
    cycle("edge_noerr", idleE(1'b0));

    // ram_rdy never comes: abort after TIMEOUT cycles and set the sticky error
    iREN    = 1'b1;
    ramload = 32'h7777_7777;
    cycle("to_req", idleE(1'b0));
    for (int c = 1; c <= TIMEOUT; c++) begin
      cycle($sformatf("to_wait%0d", c), iaccE(1'b1, 1'b0, 32'h50, 32'h7777_7777, 1'b0));
    end
    cycle("to_abort_idle", idleE(1'b1));
    // The held request is granted again, then withdrawn mid-access
    iREN = 1'b0;
    cycle("to_drop", iaccE(1'b0, 1'b0, 32'h50, 32'h7777_7777, 1'b1));
    cycle("to_sticky", idleE(1'b1));

    // Synchronous reset taken in the middle of a data write
    dWEN    = 1'b1;
    daddr   = 32'h0000_0108;
    dstore  = 32'h55AA_55AA;
    ramload = 32'h0;
    cycle("rst_req", idleE(1'b1));
    cycle("rst_dacc", daccE(1'b0, 1'b1, 1'b0, 32'h108, 32'h55AA_55AA, 32'h0, 1'b1));
    nRST = 1'b0;
    cycle("rst_assert", daccE(1'b0, 1'b1, 1'b0, 32'h108, 32'h55AA_55AA, 32'h0, 1'b1));
    nRST = 1'b1;
    cycle("rst_after", idleE(1'b0));
    dWEN = 1'b0;
    cycle("rst_regrant", daccE(1'b0, 1'b0, 1'b0, 32'h108, 32'h55AA_55AA, 32'h0, 1'b0));
    cycle("rst_final", idleE(1'b0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule : tb_memory_arbiter

// File: doc/memory_arbiter.md
# memory_arbiter

Sequences the processor's single unified RAM port between the instruction-fetch requester and the data-memory requester of the pipelined datapath. Arbitration is fixed-priority data-over-instruction, or round-robin when configured. Each access runs under a watchdog. The hazard logic stalls the pipeline on the `iwait`/`dwait` outputs. The block sits between the pipeline's fetch/memory stages and the RAM model.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles an access may wait for `ram_rdy` before it is aborted.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `iREN` in 1: instruction read request, level, held until `iwait`=0.
- `iaddr` in 32: instruction address.
- `iload` out 32: instruction read data.
- `iwait` out 1: 1 = instruction access not complete.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request. If `dREN` and `dWEN` are both 1, the access is a write.
- `daddr` in 32: data address.
- `dstore` in 32: data write value.
- `dload` out 32: data read value.
- `dwait` out 1: 1 = data access not complete.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ram_rdy` in 1: RAM reports the current access complete this cycle.
- `arb_err` out 1: sticky flag, set on watchdog timeout.

## Operation
- FSM states, held in `arb_state_t`:
  - `ARB_IDLE`: no access in progress.
  - `ARB_IACC`: instruction access in progress.
  - `ARB_DACC`: data access in progress.
- `ARB_IDLE` transitions:
  - Data request (`dREN`|`dWEN`) → `ARB_DACC`.
  - Otherwise `iREN` → `ARB_IACC`.
  - Otherwise stay.
- `ARB_IACC` drives the RAM port:
  - `ramREN`=1, `ramaddr`=`iaddr`, `iload`=`ramload`.
  - When `ram_rdy`=1: `iwait`=0 that cycle, next state `ARB_IDLE`.
- `ARB_DACC` drives the RAM port:
  - `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - `ramWEN`=`dWEN`, `ramREN`=`dREN & ~dWEN`, `dload`=`ramload`.
  - When `ram_rdy`=1: `dwait`=0, next state `ARB_IDLE`.
- Request dropped mid-access (the serving requester's enable deasserts): return to `ARB_IDLE` next cycle, no acknowledge. The RAM strobes follow the requester's enables combinationally, so they drop in the same cycle.
- Wait outputs:
  - `iwait` = ~(`ARB_IACC` & `ram_rdy`).
  - `dwait` = ~(`ARB_DACC` & `ram_rdy`).
  - Both are 1 whenever the requester is not being completed, including in `ARB_IDLE`.
- Outputs in `ARB_IDLE`:
  - `ramREN`=`ramWEN`=0.
  - `ramaddr`, `ramstore`, `iload`, `dload` = 0.
- Watchdog:
  - $clog2(`TIMEOUT`+1)-bit counter, cleared on entry to `IACC`/`DACC`, increments each access cycle without `ram_rdy`.
  - On reaching `TIMEOUT`: next state `ARB_IDLE`, `arb_err`<=1.
  - The aborted requester sees no completion; its wait stays 1.
- `arb_err` clears only on reset.
- Reset (`nRST`=0 at a rising edge), including mid-access:
  - State `ARB_IDLE`, counter 0, `arb_err` 0, round-robin pointer = instruction-last.
  - Outputs after reset: `iwait`=`dwait`=1; all RAM strobes, address and data outputs 0.

## Timing
- Grant latency: request sampled at edge N in `ARB_IDLE`; RAM strobes asserted in cycle N+1.
- Minimum access: 2 cycles (request cycle + access cycle with `ram_rdy`=1).
- Back-to-back accesses always separate by one `ARB_IDLE` cycle. Per-requester throughput is at most 1 access per 2 cycles.
- `ram_rdy` and a timeout in the same cycle: `ram_rdy` wins. The access completes, `arb_err` is unchanged.
- Outputs are combinational from registered state plus inputs. No combinational path runs from `ram_rdy` to the RAM strobes.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - With simultaneous `iREN` and data requests in `ARB_IDLE`, the grant goes to the requester not served last.
  - A 1-bit `last_grant` register, reset to instruction, updates on every completed access.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins, no `last_grant` register.

## Structure
- `diaosi_types_pkg` holds `arb_state_t` (`ARB_IDLE`, `ARB_IACC`, `ARB_DACC`) and `ARB_REQ_I`/`ARB_REQ_D` grant constants.
- Word type comes from `cpu_types_pkg`.
- One sub-module, `arb_watchdog`: timeout counter with `clear`, `count_en`, `expired` ports, parameterised by `TIMEOUT`.

## Test plan
- Reset, then `iREN`=1, `iaddr`=0x40, `ram_rdy`=1 from cycle 1 with `ramload`=0x8C010004 → `ramREN`=1, `ramaddr`=0x40 in cycle 1; `iwait`=0 and `iload`=0x8C010004 in cycle 1; state `ARB_IDLE` in cycle 2.
- `iREN`=`dWEN`=1 together, `daddr`=0x100, `dstore`=0xDEADBEEF, `ram_rdy` 2 cycles later → data served first with `ramWEN`=1 and `ramstore`=0xDEADBEEF. Then the instruction access follows.
  - Default build: data wins on every tie.
  - With `MEM_ARB_RR_EN` and sustained requests on both sides: grants alternate D, I, D, I.
- `dREN`=`dWEN`=1 → write performed, `ramREN`=0.
- `iREN` held, `ram_rdy` never asserted, `TIMEOUT`=16 → after 16 access cycles state returns to `ARB_IDLE`, `arb_err`=1 and stays 1; `iwait` stays 1.
- `ram_rdy` asserted exactly on cycle `TIMEOUT` → access completes, `arb_err` stays 0.
- `nRST`=0 during `ARB_DACC` → next cycle `ramWEN`=`ramREN`=0, `dwait`=1, `arb_err`=0, state `ARB_IDLE`.
